// File: rtl/btn_event_if.sv
// Bundle between the debouncer side and the button event generator.
// The debouncer side drives levels; the event generator returns pulses.
interface btn_event_if #(
    parameter int NUM_BTN = 5
);
    logic [NUM_BTN-1:0] debounced_btn;
    logic [NUM_BTN-1:0] press_pulse;
    logic [NUM_BTN-1:0] release_pulse;
    logic [NUM_BTN-1:0] short_pulse;
    logic [NUM_BTN-1:0] long_pulse;
    logic [NUM_BTN-1:0] repeat_pulse;
    logic [NUM_BTN-1:0] held;

    modport master (
        output debounced_btn,
        input  press_pulse,
        input  release_pulse,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  debounced_btn,
        output press_pulse,
        output release_pulse,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );
endinterface

// File: rtl/btn_event_gen.sv
// Turns debounced button levels into one-cycle press/release/tap/long/repeat
// pulses, one independent IDLE/HOLD/REPEAT machine per button.
module btn_event_gen #(
    parameter int          NUM_BTN       = 5,
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 20_000_000
) (
    input  logic clk,
    input  logic reset,
    btn_event_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [31:0] LONG_LAST   = 32'(LONG_CYCLES - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

    state_t             state_q [NUM_BTN];
    logic [31:0]        cnt_q   [NUM_BTN];
    logic [NUM_BTN-1:0] press_p0;
    logic [NUM_BTN-1:0] release_p0;
    logic [NUM_BTN-1:0] short_p0;
    logic [NUM_BTN-1:0] long_p0;
    logic [NUM_BTN-1:0] repeat_p0;
    logic [NUM_BTN-1:0] held_p0;

    // Release is tested before any counter compare so that a release on the
    // edge where long/repeat would fire suppresses that pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            press_p0   <= '0;
            release_p0 <= '0;
            short_p0   <= '0;
            long_p0    <= '0;
            repeat_p0  <= '0;
            held_p0    <= '0;
        end else begin
            press_p0   <= '0;
            release_p0 <= '0;
            short_p0   <= '0;
            long_p0    <= '0;
            repeat_p0  <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (bus.debounced_btn[i]) begin
                            state_q[i]  <= ST_HOLD;
                            cnt_q[i]    <= '0;
                            press_p0[i] <= 1'b1;
                            held_p0[i]  <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!bus.debounced_btn[i]) begin
                            state_q[i]    <= ST_IDLE;
                            cnt_q[i]      <= '0;
                            release_p0[i] <= 1'b1;
                            short_p0[i]   <= 1'b1;
                            held_p0[i]    <= 1'b0;
                        end else if (cnt_q[i] == LONG_LAST) begin
                            state_q[i] <= ST_REPEAT;
                            cnt_q[i]   <= '0;
                            long_p0[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 32'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!bus.debounced_btn[i]) begin
                            state_q[i]    <= ST_IDLE;
                            cnt_q[i]      <= '0;
                            release_p0[i] <= 1'b1;
                            held_p0[i]    <= 1'b0;
                        end else if (cnt_q[i] == REPEAT_LAST) begin
                            cnt_q[i]     <= '0;
                            repeat_p0[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 32'd1;
                        end
                    end
                    default: begin
                        state_q[i] <= ST_IDLE;
                        cnt_q[i]   <= '0;
                        held_p0[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.press_pulse   = press_p0;
    assign bus.release_pulse = release_p0;
    assign bus.short_pulse   = short_p0;
    assign bus.long_pulse    = long_p0;
    assign bus.repeat_pulse  = repeat_p0;
    assign bus.held          = held_p0;

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with LONG_CYCLES=10, REPEAT_CYCLES=4.
module tb_btn_event_gen;

    localparam int NB = 5;

    typedef struct {
        logic          rst;
        logic [NB-1:0] btn;
        logic [NB-1:0] e_press;
        logic [NB-1:0] e_rel;
        logic [NB-1:0] e_short;
        logic [NB-1:0] e_long;
        logic [NB-1:0] e_rep;
        logic [NB-1:0] e_held;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    btn_event_if #(.NUM_BTN(NB)) bus ();

    btn_event_gen #(
        .NUM_BTN      (NB),
        .LONG_CYCLES  (10),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    vec_t vecs [16];

    task automatic step_chk(input string nm, input logic r, input logic [NB-1:0] b,
                            input logic [NB-1:0] ep, input logic [NB-1:0] er,
                            input logic [NB-1:0] es, input logic [NB-1:0] el,
                            input logic [NB-1:0] erp, input logic [NB-1:0] eh);
        logic [6*NB-1:0] act;
        logic [6*NB-1:0] exp_v;
        reset = r;
        bus.debounced_btn = b;
        @(posedge clk);
        #1;
        act   = {bus.press_pulse, bus.release_pulse, bus.short_pulse,
                 bus.long_pulse, bus.repeat_pulse, bus.held};
        exp_v = {ep, er, es, el, erp, eh};
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s press/rel/short/long/rep/held got %b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
                     nm, act[29:25], act[24:20], act[19:15], act[14:10], act[9:5], act[4:0],
                     exp_v[29:25], exp_v[24:20], exp_v[19:15], exp_v[14:10], exp_v[9:5], exp_v[4:0]);
        end
    endtask

    initial begin
        logic [NB-1:0] b, ep, er, es, el, erp, eh;
        //            rst   btn       press     rel       short     long      rep       held
        vecs[0]  = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vecs[1]  = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vecs[2]  = '{1'b1, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vecs[3]  = '{1'b0, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111};
        vecs[4]  = '{1'b0, 5'b00000, 5'b00000, 5'b11111, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
        vecs[5]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vecs[6]  = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[7]  = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[8]  = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[9]  = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[10] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
        vecs[11] = '{1'b0, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        vecs[12] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        vecs[13] = '{1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010};
        vecs[14] = '{1'b0, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
        vecs[15] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

        reset = 1'b1;
        bus.debounced_btn = 5'b11111;
        for (int i = 0; i < 16; i++)
            step_chk($sformatf("vec%0d", i), vecs[i].rst, vecs[i].btn, vecs[i].e_press,
                     vecs[i].e_rel, vecs[i].e_short, vecs[i].e_long, vecs[i].e_rep,
                     vecs[i].e_held);

        // Long hold on btn[2]: press k=0, long k=10, repeats k=14,18,22, release k=25.
        for (int k = 0; k <= 25; k++) begin
            b   = (k < 25) ? 5'b00100 : 5'b00000;
            ep  = (k == 0) ? 5'b00100 : 5'b00000;
            el  = (k == 10) ? 5'b00100 : 5'b00000;
            erp = (k == 14 || k == 18 || k == 22) ? 5'b00100 : 5'b00000;
            er  = (k == 25) ? 5'b00100 : 5'b00000;
            eh  = (k < 25) ? 5'b00100 : 5'b00000;
            step_chk($sformatf("long_k%0d", k), 1'b0, b, ep, er, 5'b00000, el, erp, eh);
        end
        step_chk("long_idle", 1'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);

        // Release sampled on the edge the long compare would fire.
        for (int k = 0; k <= 11; k++) begin
            b  = (k < 10) ? 5'b00010 : 5'b00000;
            ep = (k == 0) ? 5'b00010 : 5'b00000;
            er = (k == 10) ? 5'b00010 : 5'b00000;
            eh = (k < 10) ? 5'b00010 : 5'b00000;
            step_chk($sformatf("bnd_long_k%0d", k), 1'b0, b, ep, er, er, 5'b0, 5'b0, eh);
        end

        // Release sampled on the edge a repeat would fire.
        for (int k = 0; k <= 15; k++) begin
            b  = (k < 14) ? 5'b00010 : 5'b00000;
            ep = (k == 0) ? 5'b00010 : 5'b00000;
            el = (k == 10) ? 5'b00010 : 5'b00000;
            er = (k == 14) ? 5'b00010 : 5'b00000;
            eh = (k < 14) ? 5'b00010 : 5'b00000;
            step_chk($sformatf("bnd_rep_k%0d", k), 1'b0, b, ep, er, 5'b0, el, 5'b0, eh);
        end

        // btn[4] in REPEAT while btn[3] is tapped; btn[3] releases as btn[4] repeats.
        for (int k = 0; k <= 29; k++) begin
            b   = 5'b00000;
            b[4] = (k < 28);
            b[3] = (k == 12 || k == 13);
            ep  = 5'b0; er = 5'b0; es = 5'b0; el = 5'b0; erp = 5'b0; eh = 5'b0;
            ep[4]  = (k == 0);
            el[4]  = (k == 10);
            erp[4] = (k == 14 || k == 18 || k == 22 || k == 26);
            er[4]  = (k == 28);
            eh[4]  = (k < 28);
            ep[3]  = (k == 12);
            er[3]  = (k == 14);
            es[3]  = (k == 14);
            eh[3]  = (k == 12 || k == 13);
            step_chk($sformatf("indep_k%0d", k), 1'b0, b, ep, er, es, el, erp, eh);
        end

        // Reset for one cycle while btn[0] is in REPEAT, then timing restarts.
        for (int k = 0; k <= 30; k++) begin
            b   = (k < 29) ? 5'b00001 : 5'b00000;
            ep  = (k == 0 || k == 17) ? 5'b00001 : 5'b00000;
            el  = (k == 10 || k == 27) ? 5'b00001 : 5'b00000;
            erp = (k == 14) ? 5'b00001 : 5'b00000;
            er  = (k == 29) ? 5'b00001 : 5'b00000;
            eh  = (k < 16 || (k >= 17 && k < 29)) ? 5'b00001 : 5'b00000;
            step_chk($sformatf("rst_mid_k%0d", k), (k == 16), b, ep, er, 5'b0, el, erp, eh);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
